// File: rtl/link_align_pkg.sv
// Shared types and constants for the non-GTX receive alignment controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package link_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_NEXT   = 3'd4,
        ST_LOCKED = 3'd5,
        ST_FAIL   = 3'd6
    } state_e;

    // 16 bit latencies x 2 sampling edges
    localparam int NUM_SETTINGS = 32;
    localparam logic [4:0] LAST_SETTING = 5'(NUM_SETTINGS - 1);

    localparam int DEF_SETTLE_CYCLES = 64;
    localparam int DEF_CHECK_CYCLES  = 1024;
    localparam int DEF_ERR_THRESH    = 4;
    localparam int DEF_RST_CYCLES    = 4;

    // Window counter width: holds (largest window - 1), never narrower than 1 bit.
    function automatic int win_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/window_counter.sv
// Loadable down counter with terminal count, timing every controller window.
// Latency: load takes effect on the next edge; o_tc is combinational from the count.
// Backpressure: none; i_en pauses counting, the count holds at zero once reached.
// Ports: i_clk/i_rstn clock and sync reset, i_load/i_load_val preload (N-1 for an
//        N-cycle window), i_en count enable, o_tc high while the count is zero.
module window_counter #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/link_align_ctrl.sv
// Sweeps non-GTX sampler latency/edge, qualifies each setting, locks and monitors.
// Latency: all outputs registered; start -> RST one edge later; one setting costs RST+SETTLE+CHECK+1 cycles.
// Backpressure: none; start is ignored outside IDLE/FAIL, enable low forces IDLE on the next edge.
// Ports: clk40/rstn clock and sync active-low reset; enable, start, align_done, align_error in;
//        bit_latency, falling_edge, auto_mode, sampler_rstn drive the sampler;
//        locked, lock_fail, relock_cnt, state report status.
module link_align_ctrl
    import link_align_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CHECK_CYCLES  = DEF_CHECK_CYCLES,
    parameter int ERR_THRESH    = DEF_ERR_THRESH,
    parameter int RST_CYCLES    = DEF_RST_CYCLES
) (
    input  logic       clk40,
    input  logic       rstn,
    input  logic       enable,
    input  logic       start,
    input  logic       align_done,
    input  logic       align_error,
    output logic [3:0] bit_latency,
    output logic       falling_edge,
    output logic       auto_mode,
    output logic       sampler_rstn,
    output logic       locked,
    output logic       lock_fail,
    output logic [7:0] relock_cnt,
    output logic [2:0] state
);

    localparam int WCW = win_width(CHECK_CYCLES, SETTLE_CYCLES);
    localparam int ECW = $clog2(CHECK_CYCLES + 1);

    localparam logic [WCW-1:0] RST_LD    = WCW'(RST_CYCLES - 1);
    localparam logic [WCW-1:0] SETTLE_LD = WCW'(SETTLE_CYCLES - 1);
    localparam logic [WCW-1:0] CHECK_LD  = WCW'(CHECK_CYCLES - 1);
    localparam logic [ECW-1:0] ERR_TH    = ECW'(ERR_THRESH);

    state_e         r_state, w_state_nxt;
    logic [4:0]     r_setting, w_setting_nxt;   // {edge, latency}
    logic [ECW-1:0] r_err_cnt, w_err_nxt;
    logic [ECW-1:0] w_err_inc;
    logic [7:0]     r_relock, w_relock_nxt;
    logic           r_sampler_rstn, r_locked, r_lock_fail;
    logic           w_win_load, w_win_en, w_win_tc;
    logic [WCW-1:0] w_win_val;

    window_counter #(.W(WCW)) u_win (
        .i_clk      (clk40),
        .i_rstn     (rstn),
        .i_load     (w_win_load),
        .i_load_val (w_win_val),
        .i_en       (w_win_en),
        .o_tc       (w_win_tc)
    );

    assign w_win_en = (r_state == ST_RST) || (r_state == ST_SETTLE) ||
                      (r_state == ST_CHECK) || (r_state == ST_LOCKED);

    // Error count including the current cycle, so an error on the last
    // cycle of a window still takes part in that window's decision.
    assign w_err_inc = (align_error && (r_err_cnt != '1)) ? r_err_cnt + ECW'(1) : r_err_cnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_setting_nxt = r_setting;
        w_err_nxt     = r_err_cnt;
        w_relock_nxt  = r_relock;
        w_win_load    = 1'b0;
        w_win_val     = RST_LD;
        case (r_state)
            ST_IDLE, ST_FAIL: begin
                if (start) begin
                    w_state_nxt   = ST_RST;
                    w_setting_nxt = '0;
                    w_win_load    = 1'b1;
                end
            end
            ST_RST: begin
                if (w_win_tc) begin
                    w_state_nxt = ST_SETTLE;
                    w_err_nxt   = '0;
                    w_win_load  = 1'b1;
                    w_win_val   = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                if (w_win_tc) begin
                    w_state_nxt = ST_CHECK;
                    w_win_load  = 1'b1;
                    w_win_val   = CHECK_LD;
                end
            end
            ST_CHECK: begin
                w_err_nxt = w_err_inc;
                if (w_win_tc) begin
                    if (align_done && (w_err_inc == '0)) begin
                        w_state_nxt = ST_LOCKED;
                        w_err_nxt   = '0;
                        w_win_load  = 1'b1;
                        w_win_val   = CHECK_LD;
                    end else begin
                        w_state_nxt = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (r_setting == LAST_SETTING) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    // latency carries into the edge bit: 15/0 -> 0/1
                    w_setting_nxt = r_setting + 5'd1;
                    w_state_nxt   = ST_RST;
                    w_win_load    = 1'b1;
                end
            end
            ST_LOCKED: begin
                w_err_nxt = w_err_inc;
                if (!align_done || (w_err_inc >= ERR_TH)) begin
                    if (r_relock != 8'hFF) begin
                        w_relock_nxt = r_relock + 8'd1;
                    end
                    w_setting_nxt = '0;
                    w_state_nxt   = ST_RST;
                    w_win_load    = 1'b1;
                end else if (w_win_tc) begin
                    // next monitor window starts with a clean count
                    w_err_nxt  = '0;
                    w_win_load = 1'b1;
                    w_win_val  = CHECK_LD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Disable wins over everything; setting and relock count are kept.
        if (!enable) begin
            w_state_nxt   = ST_IDLE;
            w_setting_nxt = r_setting;
            w_relock_nxt  = r_relock;
            w_win_load    = 1'b0;
        end
    end

    always_ff @(posedge clk40) begin
        if (!rstn) begin
            r_state        <= ST_IDLE;
            r_setting      <= '0;
            r_err_cnt      <= '0;
            r_relock       <= '0;
            r_sampler_rstn <= 1'b1;
            r_locked       <= 1'b0;
            r_lock_fail    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_setting      <= w_setting_nxt;
            r_err_cnt      <= w_err_nxt;
            r_relock       <= w_relock_nxt;
            r_sampler_rstn <= (w_state_nxt != ST_RST);
            r_locked       <= (w_state_nxt == ST_LOCKED);
            r_lock_fail    <= (w_state_nxt == ST_FAIL);
        end
    end

    assign bit_latency  = r_setting[3:0];
    assign falling_edge = r_setting[4];
    assign auto_mode    = 1'b0;
    assign sampler_rstn = r_sampler_rstn;
    assign locked       = r_locked;
    assign lock_fail    = r_lock_fail;
    assign relock_cnt   = r_relock;
    assign state        = r_state;

endmodule

// File: tb/tb_link_align_ctrl.sv
// Self-checking bench for link_align_ctrl with shortened windows.
// Expected timing comes from edge arithmetic: the start pulse is driven just after
// edge 0; setting s occupies edges 1+s*P .. (s+1)*P, P = R+S+C+1.
module tb_link_align_ctrl;
    import link_align_pkg::*;

    localparam int R  = 4;
    localparam int S  = 16;
    localparam int C  = 64;
    localparam int TH = 4;
    localparam int P  = R + S + C + 1;

    logic       clk40 = 1'b0;
    logic       rstn = 1'b0, enable = 1'b0, start = 1'b0;
    logic       align_done = 1'b0, align_error = 1'b0;
    logic [3:0] bit_latency;
    logic       falling_edge, auto_mode, sampler_rstn, locked, lock_fail;
    logic [7:0] relock_cnt;
    logic [2:0] state;

    link_align_ctrl #(
        .SETTLE_CYCLES (S),
        .CHECK_CYCLES  (C),
        .ERR_THRESH    (TH),
        .RST_CYCLES    (R)
    ) dut (
        .clk40        (clk40),
        .rstn         (rstn),
        .enable       (enable),
        .start        (start),
        .align_done   (align_done),
        .align_error  (align_error),
        .bit_latency  (bit_latency),
        .falling_edge (falling_edge),
        .auto_mode    (auto_mode),
        .sampler_rstn (sampler_rstn),
        .locked       (locked),
        .lock_fail    (lock_fail),
        .relock_cnt   (relock_cnt),
        .state        (state)
    );

    always #5 clk40 = ~clk40;

    int n_checks = 0;
    int n_fail   = 0;

    bit [31:0] good_m;
    bit [31:0] err_m;
    int        err_off[32];
    logic [7:0] relock_exp;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk40);
        #1;
    endtask

    function automatic logic [10:0] obs();
        return {state, sampler_rstn, locked, lock_fail, falling_edge, bit_latency};
    endfunction

    function automatic logic [10:0] exp_v(input logic [2:0] st, input logic srn,
                                          input logic lk, input logic lf, input int set);
        logic [4:0] s5;
        s5 = set[4:0];
        return {st, srn, lk, lf, s5};
    endfunction

    task automatic go_idle();
        enable      = 1'b0;
        start       = 1'b0;
        align_error = 1'b0;
        tick();
        chk("idle", {29'd0, state, sampler_rstn, locked, lock_fail} >> 0,
            {26'd0, ST_IDLE, 1'b1, 1'b0, 1'b0});
        chk("idle_relock", relock_cnt, relock_exp);
        enable = 1'b1;
    endtask

    // Sweep from start; stop_at > 0 halts after that edge with no end checks.
    task automatic run_sweep(input int stop_at);
        int first, end_e, fin_e, last, s, q;
        first = -1;
        for (int i = 0; i < 32; i++) begin
            if (first < 0 && good_m[i] &&
                !(err_m[i] && err_off[i] >= R + S && err_off[i] < R + S + C))
                first = i;
        end
        end_e = (first >= 0) ? (first + 1) * P : 32 * P + 1;
        fin_e = (stop_at > 0) ? -1 : end_e;
        last  = (stop_at > 0) ? stop_at : end_e;
        start       = 1'b1;
        align_done  = good_m[0];
        align_error = 1'b0;
        for (int e = 1; e <= last; e++) begin
            tick();
            start = 1'b0;
            s = (e - 1) / P;
            q = (e - 1) % P;
            if (e == fin_e) begin
                if (first >= 0) chk("lock_at", obs(), exp_v(ST_LOCKED, 1'b1, 1'b1, 1'b0, first));
                else            chk("fail_at", obs(), exp_v(ST_FAIL, 1'b1, 1'b0, 1'b1, 31));
            end else begin
                if (q == 0) chk("sweep_rst", obs(), exp_v(ST_RST, 1'b0, 1'b0, 1'b0, s));
                if (q == R) chk("sweep_settle", obs(), exp_v(ST_SETTLE, 1'b1, 1'b0, 1'b0, s));
                if (e == fin_e - 1) chk("pre_end", {locked, lock_fail}, 2'b00);
            end
            align_done  = (s < 32) ? good_m[s] : 1'b0;
            align_error = (s < 32) && err_m[s] && (err_off[s] == q);
        end
        align_error = 1'b0;
        align_done  = (fin_e > 0 && first >= 0);
    endtask

    // Locked: TH-1 errors in window 0 keep lock, TH errors in window 1 drop it.
    task automatic lock_loss();
        bit err_t[2*C+2];
        int cnt, loss_t, n, pos;
        for (int i = 0; i < 2 * C + 2; i++) err_t[i] = 1'b0;
        for (int i = 0; i < TH - 1; i++) err_t[$urandom_range(C, 1)] = 1'b1;
        n = 0;
        while (n < TH) begin
            pos = $urandom_range(2 * C, C + 1);
            if (!err_t[pos]) begin
                err_t[pos] = 1'b1;
                n++;
            end
        end
        loss_t = 0;
        cnt    = 0;
        for (int t = 1; t <= 2 * C && loss_t == 0; t++) begin
            if ((t - 1) % C == 0) cnt = 0;
            if (err_t[t]) cnt++;
            if (cnt >= TH) loss_t = t;
        end
        align_error = err_t[1];
        for (int t = 1; t <= loss_t + R; t++) begin
            tick();
            start = (t == 3);
            if (t == C) chk("win0_hold", locked, 1'b1);
            if (t == loss_t - 1) chk("pre_loss", {locked, state}, {1'b1, ST_LOCKED});
            if (t == loss_t) begin
                relock_exp++;
                chk("loss", obs(), exp_v(ST_RST, 1'b0, 1'b0, 1'b0, 0));
                chk("loss_relock", relock_cnt, relock_exp);
            end
            if (t == loss_t + R - 1) chk("srst_low", sampler_rstn, 1'b0);
            if (t == loss_t + R) chk("srst_high", {sampler_rstn, state}, {1'b1, ST_SETTLE});
            align_error = (t + 1 <= 2 * C) ? err_t[t + 1] : 1'b0;
        end
        start       = 1'b0;
        align_error = 1'b0;
    endtask

    task automatic relock_check(input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == n - 1) chk("relock_pre", locked, 1'b0);
            if (i == n) chk("relock", obs(), exp_v(ST_LOCKED, 1'b1, 1'b1, 1'b0, 0));
        end
    endtask

    task automatic done_drop();
        int d;
        d = $urandom_range(2 * C, 2);
        for (int i = 1; i <= d; i++) begin
            tick();
            if (i == d) chk("pre_drop", {locked, state}, {1'b1, ST_LOCKED});
        end
        align_done = 1'b0;
        tick();
        relock_exp++;
        chk("drop", obs(), exp_v(ST_RST, 1'b0, 1'b0, 1'b0, 0));
        chk("drop_relock", relock_cnt, relock_exp);
        align_done = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        relock_exp = 8'd0;
        for (int i = 0; i < 32; i++) err_off[i] = 0;
        repeat (3) @(posedge clk40);
        #1;
        chk("reset", obs(), exp_v(ST_IDLE, 1'b1, 1'b0, 1'b0, 0));
        chk("reset_relock", relock_cnt, 8'd0);
        chk("auto_mode", auto_mode, 1'b0);
        rstn   = 1'b1;
        enable = 1'b1;
        tick();
        chk("idle_no_start", obs(), exp_v(ST_IDLE, 1'b1, 1'b0, 1'b0, 0));

        // First setting good, then lose lock on errors and on align_done.
        good_m = '1;
        err_m  = '0;
        run_sweep(0);
        lock_loss();
        relock_check(P - 1 - R);
        done_drop();
        relock_check(P - 1);

        // Only {9,1} aligns.
        go_idle();
        good_m = 32'h1 << 25;
        run_sweep(0);

        // Error only on the last CHECK cycle of {0,0}: rejected, locks at {1,0}.
        go_idle();
        good_m     = '1;
        err_m      = 32'h1;
        err_off[0] = R + S + C - 1;
        run_sweep(0);

        // Never aligned: fail, then start restarts at {0,0}.
        go_idle();
        good_m = '0;
        err_m  = '0;
        run_sweep(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fail_restart", obs(), exp_v(ST_RST, 1'b0, 1'b0, 1'b0, 0));

        // Random good masks and error placements.
        for (int k = 0; k < 6; k++) begin
            go_idle();
            good_m = $urandom & $urandom & $urandom;
            err_m  = $urandom;
            for (int i = 0; i < 32; i++) err_off[i] = $urandom_range(P - 1, 0);
            run_sweep(0);
        end

        // Enable drop mid-SETTLE of setting {2,0}.
        go_idle();
        good_m = '0;
        err_m  = '0;
        run_sweep(2 * P + 1 + R + 5);
        enable = 1'b0;
        tick();
        chk("en_drop", obs(), exp_v(ST_IDLE, 1'b1, 1'b0, 1'b0, 2));
        chk("en_drop_relock", relock_cnt, relock_exp);
        enable = 1'b1;
        tick();
        chk("en_back_idle", obs(), exp_v(ST_IDLE, 1'b1, 1'b0, 1'b0, 2));

        // Reset mid-CHECK of setting {3,0}.
        run_sweep(3 * P + 1 + R + S + 10);
        chk("pre_rst_check", {state, sampler_rstn}, {ST_CHECK, 1'b1});
        rstn = 1'b0;
        tick();
        chk("mid_reset", obs(), exp_v(ST_IDLE, 1'b1, 1'b0, 1'b0, 0));
        chk("mid_reset_relock", relock_cnt, 8'd0);
        rstn = 1'b1;
        tick();
        chk("after_reset", obs(), exp_v(ST_IDLE, 1'b1, 1'b0, 1'b0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
